multi_timer: RTL and testbench

Parametrised multi-channel timer that generalises the free-running 8-bit timer. It provides CHANNELS independent up-counters of WIDTH bits, sharing one programmable prescaler. Each channel has a programmable terminal value, start/stop control, one-shot or periodic mode, and expiry pulse and sticky-flag outputs. It sits beside game and control logic as the shared time base for turn timeouts, blink rates and debounce windows.

---
 rtl/multi_timer.sv | 168 ++++++++++++++++
 tb/tb_multi_timer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//
// Multi-channel timer. CHANNELS independent WIDTH-bit up-counters share one
// free-running programmable prescaler. Each channel has its own terminal
// (period) register, start/stop control, one-shot or periodic mode, a
// one-cycle expiry pulse and a sticky expiry flag.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-low reset of all state
//   rst_timer  synchronous clear of channels and prescaler (periods kept)
//   prescale   tick divider: one tick every prescale+1 clock cycles
//   wr_en      write strobe for the period register selected by wr_ch
//   wr_ch      channel index for the period write (out-of-range is ignored)
//   wr_data    new period value
//   start      per-channel start/restart strobe
//   stop       per-channel stop strobe
//   periodic   per-channel mode: 1 = periodic, 0 = one-shot
//   clr_flag   per-channel sticky-flag clear
//   count_out  channel i count in bits [i*WIDTH +: WIDTH]
//   running    1 while the channel is in RUN
//   expire     one-cycle registered pulse on expiry
//   flag       sticky expiry flag
// -----------------------------------------------------------------------------
module multi_timer #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rst_timer,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS-1:0]       clr_flag,
    output logic [CHANNELS*WIDTH-1:0] count_out,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       expire,
    output logic [CHANNELS-1:0]       flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Shared prescaler
    // -------------------------------------------------------------------------
    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic                  w_tick;

    // Tick only on equality; wrap on >= so that lowering prescale below the
    // current count restarts the divider without emitting a spurious tick.
    assign w_tick = (r_pre_cnt == prescale);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre_cnt <= '0;
        end else if (rst_timer || (r_pre_cnt >= prescale)) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Channels
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t           r_state;
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] r_period;
        logic             r_expire;
        logic             r_flag;
        logic             w_wr_sel;
        logic             w_expiry;

        // An index that does not name an existing channel matches nothing.
        assign w_wr_sel = wr_en && (wr_ch == CH_W'(gi));

        // Expiry happens only on a tick in RUN that is not overridden by a
        // stop or start strobe in the same cycle. The >= compare lets a
        // period written below the current count expire on the next tick.
        assign w_expiry = (r_state == ST_RUN) && w_tick &&
                          (r_count >= r_period) &&
                          !stop[gi] && !start[gi];

        // Period register: unaffected by rst_timer, reset to all-ones so an
        // unprogrammed periodic channel wraps over the full counter range.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_period <= '1;
            end else if (w_wr_sel) begin
                r_period <= wr_data;
            end
        end

        // Channel FSM with registered count, expire and flag.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state  <= ST_IDLE;
                r_count  <= '0;
                r_expire <= 1'b0;
                r_flag   <= 1'b0;
            end else if (rst_timer) begin
                r_state  <= ST_IDLE;
                r_count  <= '0;
                r_expire <= 1'b0;
                r_flag   <= 1'b0;
            end else begin
                r_expire <= w_expiry;

                // Set beats a simultaneous clear.
                if (w_expiry) begin
                    r_flag <= 1'b1;
                end else if (clr_flag[gi]) begin
                    r_flag <= 1'b0;
                end

                if (stop[gi]) begin
                    r_state <= ST_IDLE;
                end else if (start[gi]) begin
                    // Also a restart when already running: no expire pulse.
                    r_state <= ST_RUN;
                    r_count <= '0;
                end else begin
                    case (r_state)
                        ST_RUN: begin
                            if (w_tick) begin
                                if (r_count >= r_period) begin
                                    if (periodic[gi]) begin
                                        r_count <= '0;
                                    end else begin
                                        // One-shot keeps its final count.
                                        r_state <= ST_DONE;
                                    end
                                end else begin
                                    r_count <= r_count + WIDTH'(1);
                                end
                            end
                        end
                        ST_IDLE, ST_DONE: begin
                            r_state <= r_state;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end

        assign count_out[gi*WIDTH +: WIDTH] = r_count;
        assign running[gi]                  = (r_state == ST_RUN);
        assign expire[gi]                   = r_expire;
        assign flag[gi]                     = r_flag;
    end

endmodule

// File: tb/tb_multi_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_timer
//
// Directed bench for multi_timer (WIDTH=8, CHANNELS=4, PRESCALE_W=8).
// A table of per-cycle {inputs, expected outputs} records covers periodic
// and one-shot operation, flag handling, control conflicts, period rewrites
// and prescaler behaviour. Hand-written sequences cover async reset,
// the all-ones reset period and concurrent-channel independence.
// -----------------------------------------------------------------------------
module tb_multi_timer;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int PW = 8;

    logic            clk       = 1'b0;
    logic            rst       = 1'b0;
    logic            rst_timer = 1'b0;
    logic [PW-1:0]   prescale  = '0;
    logic            wr_en     = 1'b0;
    logic [1:0]      wr_ch     = '0;
    logic [W-1:0]    wr_data   = '0;
    logic [CH-1:0]   start     = '0;
    logic [CH-1:0]   stop      = '0;
    logic [CH-1:0]   periodic  = '0;
    logic [CH-1:0]   clr_flag  = '0;
    logic [CH*W-1:0] count_out;
    logic [CH-1:0]   running;
    logic [CH-1:0]   expire;
    logic [CH-1:0]   flag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_timer #(
        .WIDTH      (W),
        .CHANNELS   (CH),
        .PRESCALE_W (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rst_timer (rst_timer),
        .prescale  (prescale),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .clr_flag  (clr_flag),
        .count_out (count_out),
        .running   (running),
        .expire    (expire),
        .flag      (flag)
    );

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  sp;
        logic [3:0]  per;
        logic [3:0]  clr;
        logic        we;
        logic [1:0]  wch;
        logic [7:0]  wd;
        logic [7:0]  ps;
        logic        rt;
        logic [31:0] e_cnt;
        logic [3:0]  e_run;
        logic [3:0]  e_exp;
        logic [3:0]  e_flag;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] c(input int ch, input int v);
        return 32'(v) << (8 * ch);
    endfunction

    task automatic add(input logic [3:0] st, input logic [3:0] sp,
                       input logic [3:0] per, input logic [3:0] clr,
                       input logic we, input logic [1:0] wch,
                       input logic [7:0] wd, input logic [7:0] ps,
                       input logic rt, input logic [31:0] e_cnt,
                       input logic [3:0] e_run, input logic [3:0] e_exp,
                       input logic [3:0] e_flag);
        vec_t v;
        v.st = st; v.sp = sp; v.per = per; v.clr = clr;
        v.we = we; v.wch = wch; v.wd = wd; v.ps = ps; v.rt = rt;
        v.e_cnt = e_cnt; v.e_run = e_run; v.e_exp = e_exp; v.e_flag = e_flag;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst_timer = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        start = '0; stop = '0; clr_flag = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hit;
        int n;
        logic [3:0] exp_mask;

        // ---------------------------------------------------------------
        // Table: st sp per clr | we wch wd | ps rt | cnt run exp flag
        // ---------------------------------------------------------------
        // Periodic ch1, period 3, prescale 0
        add(4'b0000,4'b0000,4'b0000,4'b0000, 1,2'd1,8'd3, 8'd0,0, 32'h0,     4'b0000,4'b0000,4'b0000);
        add(4'b0010,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,1),    4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,2),    4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,3),    4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0010,4'b0010,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,1),    4'b0010,4'b0000,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0010, 0,2'd0,8'd0, 8'd0,0, c(1,2),    4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,3),    4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0010,4'b0010,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,1),    4'b0010,4'b0000,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,2),    4'b0010,4'b0000,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,3),    4'b0010,4'b0000,4'b0010);
        // clr_flag on the expiry edge: set wins
        add(4'b0000,4'b0000,4'b0010,4'b0010, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0010,4'b0010,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,1),    4'b0010,4'b0000,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,2),    4'b0010,4'b0000,4'b0010);
        // stop holds count; start+stop together -> IDLE
        add(4'b0000,4'b0010,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,2),    4'b0000,4'b0000,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,2),    4'b0000,4'b0000,4'b0010);
        add(4'b0010,4'b0010,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,2),    4'b0000,4'b0000,4'b0010);
        add(4'b0010,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0010,4'b0000,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,1),    4'b0010,4'b0000,4'b0010);
        // restart while running: count back to 0, no expire
        add(4'b0010,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0010,4'b0000,4'b0010);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,1),    4'b0010,4'b0000,4'b0010);
        // rst_timer mid-run, then restart reproduces period 3
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,1, 32'h0,     4'b0000,4'b0000,4'b0000);
        add(4'b0010,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,1),    4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,2),    4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(1,3),    4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0010,4'b0010,4'b0010);
        // One-shot ch2, period 2, prescale 1
        add(4'b0000,4'b0010,4'b0010,4'b0000, 1,2'd2,8'd2, 8'd0,0, 32'h0,     4'b0000,4'b0000,4'b0010);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,1, 32'h0,     4'b0000,4'b0000,4'b0000);
        add(4'b0100,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, 32'h0,     4'b0100,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, c(2,1),    4'b0100,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, c(2,1),    4'b0100,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, c(2,2),    4'b0100,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, c(2,2),    4'b0100,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, c(2,2),    4'b0000,4'b0100,4'b0100);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, c(2,2),    4'b0000,4'b0000,4'b0100);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, c(2,2),    4'b0000,4'b0000,4'b0100);
        add(4'b0100,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, 32'h0,     4'b0100,4'b0000,4'b0100);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd1,0, c(2,1),    4'b0100,4'b0000,4'b0100);
        // Period rewritten below current count on ch0
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd0,1, 32'h0,     4'b0000,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 1,2'd0,8'd7, 8'd0,0, 32'h0,     4'b0000,4'b0000,4'b0000);
        add(4'b0001,4'b0000,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0001,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(0,1),    4'b0001,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(0,2),    4'b0001,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(0,3),    4'b0001,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(0,4),    4'b0001,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(0,5),    4'b0001,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0001,4'b0000, 1,2'd0,8'd1, 8'd0,0, c(0,6),    4'b0001,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0001,4'b0001,4'b0001);
        add(4'b0000,4'b0000,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, c(0,1),    4'b0001,4'b0000,4'b0001);
        add(4'b0000,4'b0000,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0001,4'b0001,4'b0001);
        add(4'b0000,4'b0001,4'b0001,4'b0000, 0,2'd0,8'd0, 8'd0,0, 32'h0,     4'b0000,4'b0000,4'b0001);
        // Prescale lowered below pre_cnt: wrap without a tick
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd0,1, 32'h0,     4'b0000,4'b0000,4'b0000);
        add(4'b0010,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd5,0, 32'h0,     4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd5,0, 32'h0,     4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd5,0, 32'h0,     4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd1,0, 32'h0,     4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd1,0, 32'h0,     4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0010,4'b0000, 0,2'd0,8'd0, 8'd1,0, c(1,1),    4'b0010,4'b0000,4'b0000);
        add(4'b0000,4'b0000,4'b0000,4'b0000, 0,2'd0,8'd0, 8'd0,1, 32'h0,     4'b0000,4'b0000,4'b0000);

        // ---------------------------------------------------------------
        // Power-on reset
        // ---------------------------------------------------------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset count_out", count_out, 32'h0);
        chk("reset running", 32'(running), 32'h0);
        chk("reset expire", 32'(expire), 32'h0);
        chk("reset flag", 32'(flag), 32'h0);
        rst = 1'b1;
        step();
        chk("post-reset count_out", count_out, 32'h0);
        chk("post-reset running", 32'(running), 32'h0);

        // ---------------------------------------------------------------
        // Table-driven vectors
        // ---------------------------------------------------------------
        foreach (vecs[i]) begin
            start = vecs[i].st; stop = vecs[i].sp; periodic = vecs[i].per;
            clr_flag = vecs[i].clr; wr_en = vecs[i].we; wr_ch = vecs[i].wch;
            wr_data = vecs[i].wd; prescale = vecs[i].ps; rst_timer = vecs[i].rt;
            step();
            $display("[TB] vec %0d: count_out=%h running=%b expire=%b flag=%b",
                     i, count_out, running, expire, flag);
            chk($sformatf("vec%0d count_out", i), count_out, vecs[i].e_cnt);
            chk($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].e_run));
            chk($sformatf("vec%0d expire", i), 32'(expire), 32'(vecs[i].e_exp));
            chk($sformatf("vec%0d flag", i), 32'(flag), 32'(vecs[i].e_flag));
        end
        clear_inputs();
        prescale = '0;
        periodic = '0;

        // ---------------------------------------------------------------
        // Async reset mid-count (ch0 period 1, ch1 period 3)
        // ---------------------------------------------------------------
        start = 4'b0011; periodic = 4'b0011;
        step();
        start = '0;
        repeat (5) step();
        $display("[TB] pre-async-reset: count_out=%h flag=%b", count_out, flag);
        chk("pre-async count_out", count_out, 32'h0000_0101);
        chk("pre-async flag", 32'(flag), 32'h3);
        #3;
        rst = 1'b0;
        #1;
        $display("[TB] async reset asserted: count_out=%h running=%b flag=%b",
                 count_out, running, flag);
        chk("async count_out", count_out, 32'h0);
        chk("async running", 32'(running), 32'h0);
        chk("async expire", 32'(expire), 32'h0);
        chk("async flag", 32'(flag), 32'h0);
        periodic = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("after async release count_out", count_out, 32'h0);

        // ---------------------------------------------------------------
        // Reset period is all-ones: ch0 periodic expires after 256 cycles
        // ---------------------------------------------------------------
        start = 4'b0001; periodic = 4'b0001;
        step();
        start = '0;
        n_hit = 0;
        n = 0;
        while (n_hit == 0 && n < 300) begin
            n++;
            step();
            if (expire[0]) n_hit = n;
        end
        $display("[TB] ch0 reset-period first expire after %0d cycles", n_hit);
        chk("reset period ch0 expire interval", 32'(n_hit), 32'd256);
        chk("reset period ch0 count at expire", count_out, 32'h0);

        // ---------------------------------------------------------------
        // Independence: periods 0, 1, 5, 255 running together
        // ---------------------------------------------------------------
        rst_timer = 1'b1;
        step();
        rst_timer = 1'b0;
        wr_en = 1'b1;
        wr_ch = 2'd0; wr_data = 8'd0;   step();
        wr_ch = 2'd1; wr_data = 8'd1;   step();
        wr_ch = 2'd2; wr_data = 8'd5;   step();
        wr_ch = 2'd3; wr_data = 8'd255; step();
        wr_en = 1'b0;
        start = 4'b1111; periodic = 4'b1111;
        step();
        start = '0;
        chk("indep running", 32'(running), 32'hf);
        for (int k = 1; k <= 520; k++) begin
            step();
            exp_mask[0] = 1'b1;
            exp_mask[1] = ((k % 2) == 0);
            exp_mask[2] = ((k % 6) == 0);
            exp_mask[3] = ((k % 256) == 0);
            chk($sformatf("indep expire cycle %0d", k), 32'(expire), 32'(exp_mask));
        end
        $display("[TB] independence run done: count_out=%h flag=%b", count_out, flag);
        chk("indep flag", 32'(flag), 32'hf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
